harmony_voice_scheduler: RTL and testbench

//  Time-multiplexed mix scheduler for the 36-key, three-octave piano tone bank.
//  On each audio sample tick it snapshots the pressed keys, then walks a shared

---
 rtl/harmony_voice_scheduler.sv | 179 +++++++++++++++++
 tb/tb_harmony_voice_scheduler.sv | 377 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/harmony_voice_scheduler.sv
// rtl/harmony_voice_scheduler.sv - time-multiplexed key-slot mix scheduler for the piano tone bank
module harmony_voice_scheduler #(
  parameter int NUM_KEYS   = 36,
  parameter int MAX_VOICES = 4,
  parameter int SHIFT      = 2,
  parameter int SW         = 16
) (
  input  logic                CLOCK_50,
  input  logic                rst,
  input  logic                sample_tick,
  input  logic [NUM_KEYS-1:0] key_down,
  output logic [5:0]          note_sel,
  input  logic [SW-1:0]       note_sample,
  output logic [SW-1:0]       harm_out,
  output logic                harm_valid,
  output logic                busy,
  output logic [2:0]          active_voices,
  output logic                overrun
);

  // Headroom bits above SW so MAX_VOICES full-scale samples never wrap;
  // never fewer than three.
  localparam int GROW = (($clog2(MAX_VOICES) + 1) > 3) ? ($clog2(MAX_VOICES) + 1) : 3;
  localparam int AW   = SW + GROW;

  localparam logic [5:0] LAST_IDX = 6'(NUM_KEYS - 1);
  localparam logic [2:0] MAXV     = 3'(MAX_VOICES);

  // Saturation bounds expressed at accumulator width.
  localparam logic signed [AW-1:0] SAT_MAX = {{(AW-SW+1){1'b0}}, {(SW-1){1'b1}}};
  localparam logic signed [AW-1:0] SAT_MIN = {{(AW-SW+1){1'b1}}, {(SW-1){1'b0}}};

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SCAN  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_OUT   = 2'd3;

  logic [1:0]             state_q,     state_d;
  logic [5:0]             note_sel_q,  note_sel_d;
  logic [NUM_KEYS-1:0]    key_snap_q,  key_snap_d;
  logic signed [AW-1:0]   acc_q,       acc_d;
  logic [2:0]             vcnt_q,      vcnt_d;
  logic                   cap_en_q,    cap_en_d;
  logic [5:0]             cap_idx_q,   cap_idx_d;
  logic [SW-1:0]          harm_out_q,  harm_out_d;
  logic                   harm_vld_q,  harm_vld_d;
  logic                   busy_q,      busy_d;
  logic [2:0]             act_vox_q,   act_vox_d;
  logic                   overrun_q,   overrun_d;

  logic                   take;
  logic signed [AW-1:0]   sample_ext;
  logic signed [AW-1:0]   acc_cap;
  logic [2:0]             vcnt_cap;
  logic signed [AW-1:0]   scaled;
  logic [SW-1:0]          sat_val;

  // Capture path: note_sample belongs to the slot presented one cycle earlier
  // (cap_idx_q); it is summed only if that key was held and voices remain.
  always_comb begin
    sample_ext = {{(AW-SW){note_sample[SW-1]}}, note_sample};
    take       = cap_en_q && key_snap_q[cap_idx_q] && (vcnt_q < MAXV);
    acc_cap    = take ? (acc_q + sample_ext) : acc_q;
    vcnt_cap   = take ? (vcnt_q + 3'd1) : vcnt_q;
  end

  // Scale by arithmetic shift (floor) and clamp to the signed SW-bit range.
  always_comb begin
    scaled = acc_cap >>> SHIFT;
    if (scaled > SAT_MAX) begin
      sat_val = SAT_MAX[SW-1:0];
    end else if (scaled < SAT_MIN) begin
      sat_val = SAT_MIN[SW-1:0];
    end else begin
      sat_val = scaled[SW-1:0];
    end
  end

  // Scheduler next-state: accept tick, walk slots, drain the last capture,
  // publish the mix.  The result is registered on the DRAIN->OUT edge so it
  // is already visible while OUT pulses harm_valid.
  always_comb begin
    state_d    = state_q;
    note_sel_d = note_sel_q;
    key_snap_d = key_snap_q;
    acc_d      = acc_q;
    vcnt_d     = vcnt_q;
    cap_en_d   = 1'b0;
    cap_idx_d  = note_sel_q;
    harm_out_d = harm_out_q;
    harm_vld_d = 1'b0;
    busy_d     = busy_q;
    act_vox_d  = act_vox_q;
    overrun_d  = overrun_q;

    case (state_q)
      S_IDLE: begin
        if (sample_tick) begin
          key_snap_d = key_down;
          note_sel_d = 6'd0;
          acc_d      = '0;
          vcnt_d     = 3'd0;
          busy_d     = 1'b1;
          state_d    = S_SCAN;
        end
      end
      S_SCAN: begin
        cap_en_d = 1'b1;
        acc_d    = acc_cap;
        vcnt_d   = vcnt_cap;
        if (note_sel_q == LAST_IDX) begin
          note_sel_d = 6'd0;
          state_d    = S_DRAIN;
        end else begin
          note_sel_d = note_sel_q + 6'd1;
        end
      end
      S_DRAIN: begin
        acc_d      = acc_cap;
        vcnt_d     = vcnt_cap;
        harm_out_d = sat_val;
        act_vox_d  = vcnt_cap;
        harm_vld_d = 1'b1;
        state_d    = S_OUT;
      end
      S_OUT: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // A tick while a mix is in flight is dropped but remembered.
    if (state_q != S_IDLE && sample_tick) begin
      overrun_d = 1'b1;
    end
  end

  // State registers with synchronous active-low reset; reset aborts any scan.
  always_ff @(posedge CLOCK_50) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      note_sel_q <= 6'd0;
      key_snap_q <= '0;
      acc_q      <= '0;
      vcnt_q     <= 3'd0;
      cap_en_q   <= 1'b0;
      cap_idx_q  <= 6'd0;
      harm_out_q <= '0;
      harm_vld_q <= 1'b0;
      busy_q     <= 1'b0;
      act_vox_q  <= 3'd0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      note_sel_q <= note_sel_d;
      key_snap_q <= key_snap_d;
      acc_q      <= acc_d;
      vcnt_q     <= vcnt_d;
      cap_en_q   <= cap_en_d;
      cap_idx_q  <= cap_idx_d;
      harm_out_q <= harm_out_d;
      harm_vld_q <= harm_vld_d;
      busy_q     <= busy_d;
      act_vox_q  <= act_vox_d;
      overrun_q  <= overrun_d;
    end
  end

  assign note_sel      = note_sel_q;
  assign harm_out      = harm_out_q;
  assign harm_valid    = harm_vld_q;
  assign busy          = busy_q;
  assign active_voices = act_vox_q;
  assign overrun       = overrun_q;

endmodule

// File: tb/tb_harmony_voice_scheduler.sv
// tb/tb_harmony_voice_scheduler.sv - randomized self-checking bench for harmony_voice_scheduler
module tb_harmony_voice_scheduler;

  logic        CLOCK_50 = 1'b0;
  logic        rst;
  logic        sample_tick;
  logic [35:0] key_down;
  logic [15:0] note_sample = 16'h0000;

  logic [5:0]  note_sel,      note_sel0;
  logic [15:0] harm_out,      harm_out0;
  logic        harm_valid,    harm_valid0;
  logic        busy,          busy0;
  logic [2:0]  active_voices, active_voices0;
  logic        overrun,       overrun0;

  int checks = 0;
  int errors = 0;
  bit exp_ovr = 1'b0;

  logic [15:0] tab [36];

  always #5 CLOCK_50 = ~CLOCK_50;

  harmony_voice_scheduler #(.SHIFT(2)) u_dut (
    .CLOCK_50(CLOCK_50), .rst(rst), .sample_tick(sample_tick), .key_down(key_down),
    .note_sel(note_sel), .note_sample(note_sample), .harm_out(harm_out),
    .harm_valid(harm_valid), .busy(busy), .active_voices(active_voices), .overrun(overrun)
  );

  harmony_voice_scheduler #(.SHIFT(0)) u_dut0 (
    .CLOCK_50(CLOCK_50), .rst(rst), .sample_tick(sample_tick), .key_down(key_down),
    .note_sel(note_sel0), .note_sample(note_sample), .harm_out(harm_out0),
    .harm_valid(harm_valid0), .busy(busy0), .active_voices(active_voices0), .overrun(overrun0)
  );

  // External registered note mux: output follows the previous cycle's note_sel.
  always @(posedge CLOCK_50) note_sample <= tab[note_sel];

  // Reference: sum the first four held keys in ascending order.
  function automatic int mix_sum(input logic [35:0] keys, output int nv);
    int s;
    s  = 0;
    nv = 0;
    for (int k = 0; k < 36; k++) begin
      if (keys[k] && nv < 4) begin
        s  += int'($signed(tab[k]));
        nv += 1;
      end
    end
    return s;
  endfunction

  function automatic logic [15:0] clamp16(input int v);
    if (v > 32767)  return 16'h7FFF;
    if (v < -32768) return 16'h8000;
    return v[15:0];
  endfunction

  // Floor division by 2^sh, written without shifts.
  function automatic int floor_div(input int v, input int sh);
    int d, q;
    d = 1;
    for (int i = 0; i < sh; i++) d *= 2;
    q = v / d;
    if ((v % d) != 0 && v < 0) q -= 1;
    return q;
  endfunction

  function automatic logic [35:0] rand_keys();
    logic [35:0] k;
    int n;
    k = '0;
    n = $urandom_range(0, 7);
    for (int i = 0; i < n; i++) k[$urandom_range(0, 35)] = 1'b1;
    return k;
  endfunction

  task automatic fill_tab(input int mode);
    for (int k = 0; k < 36; k++) begin
      case (mode)
        0:       tab[k] = 16'($urandom);
        1:       tab[k] = ($urandom_range(0, 1) == 1) ? 16'h7FFF : 16'h8000;
        default: tab[k] = 16'($urandom_range(0, 255)) - 16'd128;
      endcase
    end
  endtask

  task automatic fill_const(input logic [15:0] v);
    for (int k = 0; k < 36; k++) tab[k] = v;
  endtask

  // Observations collected by do_mix
  int          obs_hv_cnt, obs_hv0_cnt, obs_hv_cyc, obs_busy_low;
  logic [15:0] obs_out, obs_out0, obs_hold, obs_hold0, obs_rst_out;
  logic [2:0]  obs_av, obs_av0, obs_rst_av;
  logic        obs_rst_busy, obs_rst_ovr;
  logic [5:0]  obs_rst_nsel;
  logic [5:0]  obs_nsel [0:39];

  // Drives one tick (caller sits at a negedge) and records 39 cycles of outputs.
  task automatic do_mix(input logic [35:0] keys, input logic [35:0] keys_mid,
                        input int mid_cyc, input int ovr_cyc, input int rst_cyc);
    key_down     = keys;
    sample_tick  = 1'b1;
    obs_hv_cnt   = 0;
    obs_hv0_cnt  = 0;
    obs_hv_cyc   = 0;
    obs_busy_low = 0;
    obs_out      = 16'hxxxx;
    obs_out0     = 16'hxxxx;
    obs_av       = 3'bxxx;
    obs_av0      = 3'bxxx;
    for (int c = 1; c <= 39; c++) begin
      @(negedge CLOCK_50);
      obs_nsel[c] = note_sel;
      if (harm_valid) begin
        obs_hv_cnt++;
        if (obs_hv_cyc == 0) begin
          obs_hv_cyc = c;
          obs_out    = harm_out;
          obs_out0   = harm_out0;
          obs_av     = active_voices;
          obs_av0    = active_voices0;
        end
      end
      if (harm_valid0) obs_hv0_cnt++;
      if (!busy && obs_busy_low == 0) obs_busy_low = c;
      if (c == rst_cyc + 1) begin
        obs_rst_busy = busy;
        obs_rst_out  = harm_out;
        obs_rst_nsel = note_sel;
        obs_rst_av   = active_voices;
        obs_rst_ovr  = overrun;
      end
      sample_tick = (c == ovr_cyc);
      if (c == mid_cyc) key_down = keys_mid;
      rst = (c == rst_cyc) ? 1'b0 : 1'b1;
    end
    obs_hold  = harm_out;
    obs_hold0 = harm_out0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLOCK_50);
      sample_tick = 1'(i % 2);
      key_down    = rand_keys();
    end
    checks++;
    if ({harm_out, note_sel, active_voices, harm_valid, busy, overrun} !== 28'd0) begin
      errors++;
      $display("FAIL reset_state got out=%h sel=%0d av=%0d hv=%b busy=%b ovr=%b want all zero",
               harm_out, note_sel, active_voices, harm_valid, busy, overrun);
    end
    sample_tick = 1'b0;
    rst = 1'b1;
    @(negedge CLOCK_50);
    checks++;
    if (busy !== 1'b0 || harm_out0 !== 16'h0000) begin
      errors++;
      $display("FAIL reset_release got busy=%b out0=%h want 0 0", busy, harm_out0);
    end
  endtask

  task automatic test_single_key();
    int bad;
    fill_const(16'h1000);
    do_mix(36'h1 << 9, 36'h1 << 9, 0, 0, 0);
    checks++;
    if (obs_hv_cnt !== 1 || obs_hv_cyc !== 38 || obs_hv0_cnt !== 1) begin
      errors++;
      $display("FAIL single_latency got cnt=%0d cyc=%0d cnt0=%0d want 1 38 1", obs_hv_cnt, obs_hv_cyc, obs_hv0_cnt);
    end
    checks++;
    if (obs_out !== 16'h0400 || obs_av !== 3'd1) begin
      errors++;
      $display("FAIL single_value got out=%h av=%0d want 0400 1", obs_out, obs_av);
    end
    checks++;
    if (obs_out0 !== 16'h1000) begin
      errors++;
      $display("FAIL single_noshift got %h want 1000", obs_out0);
    end
    bad = 0;
    for (int c = 1; c <= 37; c++) if (obs_nsel[c] !== ((c <= 36) ? 6'(c - 1) : 6'd0)) bad++;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL note_sel_walk got %0d wrong cycles want 0", bad);
    end
    checks++;
    if (obs_busy_low !== 39) begin
      errors++;
      $display("FAIL busy_window got first low cycle %0d want 39", obs_busy_low);
    end
    repeat (3) @(negedge CLOCK_50);
    checks++;
    if (harm_out !== 16'h0400 || harm_valid !== 1'b0) begin
      errors++;
      $display("FAIL hold got out=%h hv=%b want 0400 0", harm_out, harm_valid);
    end
  endtask

  task automatic test_voice_limit();
    logic [35:0] k;
    k = '0;
    k[0] = 1'b1; k[5] = 1'b1; k[12] = 1'b1; k[20] = 1'b1; k[30] = 1'b1;
    fill_const(16'h7FFF);
    do_mix(k, k, 0, 0, 0);
    checks++;
    if (obs_out !== 16'h7FFF || obs_av !== 3'd4 || obs_out0 !== 16'h7FFF || obs_av0 !== 3'd4) begin
      errors++;
      $display("FAIL voice_limit got out=%h av=%0d out0=%h av0=%0d want 7fff 4 7fff 4",
               obs_out, obs_av, obs_out0, obs_av0);
    end
    fill_const(16'h0000);
    tab[30] = 16'h0100;
    do_mix(k, k, 0, 0, 0);
    checks++;
    if (obs_out !== 16'h0000 || obs_av !== 3'd4) begin
      errors++;
      $display("FAIL fifth_key_ignored got out=%h av=%0d want 0000 4", obs_out, obs_av);
    end
  endtask

  task automatic test_negative();
    fill_const(16'h8000);
    do_mix(36'h1, 36'h1, 0, 0, 0);
    checks++;
    if (obs_out !== 16'hE000 || obs_out0 !== 16'h8000 || obs_av !== 3'd1) begin
      errors++;
      $display("FAIL negative got out=%h out0=%h av=%0d want e000 8000 1", obs_out, obs_out0, obs_av);
    end
    fill_const(16'h7000);
    do_mix(36'h6, 36'h6, 0, 0, 0);
    checks++;
    if (obs_out0 !== 16'h7FFF || obs_out !== 16'h3800 || obs_av0 !== 3'd2) begin
      errors++;
      $display("FAIL saturate got out0=%h out=%h av0=%0d want 7fff 3800 2", obs_out0, obs_out, obs_av0);
    end
    fill_const(16'h8000);
    do_mix(36'h7, 36'h7, 0, 0, 0);
    checks++;
    if (obs_out0 !== 16'h8000 || obs_out !== 16'hA000) begin
      errors++;
      $display("FAIL saturate_neg got out0=%h out=%h want 8000 a000", obs_out0, obs_out);
    end
  endtask

  task automatic test_back_to_back();
    logic [35:0] k;
    int nv, s;
    for (int i = 0; i < 3; i++) begin
      fill_tab(i);
      k = rand_keys();
      s = mix_sum(k, nv);
      do_mix(k, k, 0, 0, 0);
      checks++;
      if (obs_hv_cyc !== 38 || obs_out !== clamp16(floor_div(s, 2)) || obs_av !== 3'(nv) || overrun !== 1'b0) begin
        errors++;
        $display("FAIL back_to_back%0d got cyc=%0d out=%h av=%0d ovr=%b want 38 %h %0d 0",
                 i, obs_hv_cyc, obs_out, obs_av, overrun, clamp16(floor_div(s, 2)), nv);
      end
    end
  endtask

  task automatic test_snapshot();
    logic [35:0] k, km;
    int nv, s;
    fill_tab(2);
    k = rand_keys();
    k[3] = 1'b1;
    km = k;
    km[3] = 1'b0;
    km[0] = 1'b1;
    s = mix_sum(k, nv);
    do_mix(k, km, 5, 0, 0);
    checks++;
    if (obs_out !== clamp16(floor_div(s, 2)) || obs_out0 !== clamp16(s) || obs_av !== 3'(nv)) begin
      errors++;
      $display("FAIL snapshot got out=%h out0=%h av=%0d want %h %h %0d",
               obs_out, obs_out0, obs_av, clamp16(floor_div(s, 2)), clamp16(s), nv);
    end
    fill_tab(0);
    do_mix('0, 36'hF_FFFF_FFFF, 2, 0, 0);
    checks++;
    if (obs_hv_cnt !== 1 || obs_hv_cyc !== 38 || obs_out !== 16'h0000 || obs_av !== 3'd0) begin
      errors++;
      $display("FAIL no_keys got cnt=%0d cyc=%0d out=%h av=%0d want 1 38 0000 0",
               obs_hv_cnt, obs_hv_cyc, obs_out, obs_av);
    end
  endtask

  task automatic test_random();
    logic [35:0] k, km;
    int nv, s, mid, ovr;
    for (int i = 0; i < 16; i++) begin
      fill_tab($urandom_range(0, 2));
      k   = rand_keys();
      km  = rand_keys();
      mid = $urandom_range(1, 36);
      ovr = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 38) : 0;
      s   = mix_sum(k, nv);
      do_mix(k, km, mid, ovr, 0);
      if (ovr != 0) exp_ovr = 1'b1;
      checks++;
      if (obs_hv_cnt !== 1 || obs_hv_cyc !== 38 || obs_out !== clamp16(floor_div(s, 2)) ||
          obs_out0 !== clamp16(s) || obs_av !== 3'(nv) || overrun !== exp_ovr) begin
        errors++;
        $display("FAIL random%0d got cnt=%0d cyc=%0d out=%h out0=%h av=%0d ovr=%b want 1 38 %h %h %0d %b",
                 i, obs_hv_cnt, obs_hv_cyc, obs_out, obs_out0, obs_av, overrun,
                 clamp16(floor_div(s, 2)), clamp16(s), nv, exp_ovr);
      end
    end
  endtask

  task automatic test_overrun();
    logic [35:0] k;
    int nv, s;
    fill_tab(0);
    k = rand_keys();
    s = mix_sum(k, nv);
    do_mix(k, k, 0, 10, 0);
    exp_ovr = 1'b1;
    checks++;
    if (obs_hv_cnt !== 1 || obs_hv_cyc !== 38 || obs_out !== clamp16(floor_div(s, 2)) || overrun !== 1'b1) begin
      errors++;
      $display("FAIL overrun got cnt=%0d cyc=%0d out=%h ovr=%b want 1 38 %h 1",
               obs_hv_cnt, obs_hv_cyc, obs_out, overrun, clamp16(floor_div(s, 2)));
    end
    do_mix(k, k, 0, 0, 0);
    checks++;
    if (overrun !== 1'b1 || obs_hv_cyc !== 38) begin
      errors++;
      $display("FAIL overrun_sticky got ovr=%b cyc=%0d want 1 38", overrun, obs_hv_cyc);
    end
  endtask

  task automatic test_reset_mid();
    fill_tab(0);
    do_mix(36'hF_FFFF_FFFF, 36'hF_FFFF_FFFF, 0, 0, 20);
    exp_ovr = 1'b0;
    checks++;
    if (obs_rst_busy !== 1'b0 || obs_rst_out !== 16'h0000 || obs_rst_nsel !== 6'd0 ||
        obs_rst_av !== 3'd0 || obs_rst_ovr !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid got busy=%b out=%h sel=%0d av=%0d ovr=%b want 0 0000 0 0 0",
               obs_rst_busy, obs_rst_out, obs_rst_nsel, obs_rst_av, obs_rst_ovr);
    end
    checks++;
    if (obs_hv_cnt !== 0 || obs_hv0_cnt !== 0 || obs_hold !== 16'h0000) begin
      errors++;
      $display("FAIL reset_abort got hv=%0d hv0=%0d out=%h want 0 0 0000", obs_hv_cnt, obs_hv0_cnt, obs_hold);
    end
  endtask

  initial begin
    rst         = 1'b0;
    sample_tick = 1'b0;
    key_down    = '0;
    fill_const(16'h0000);
    test_reset();
    test_single_key();
    test_voice_limit();
    test_negative();
    test_back_to_back();
    test_snapshot();
    test_random();
    test_overrun();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
